insn_loader: RTL and testbench
==============================

Name: insn_loader

Overview:
- Writer side of the instruction-memory interface: takes a byte stream from a host link, packs it into 32-bit instruction words and writes them into the `memory` instance that holds instructions.
- The core fetches from that memory with `w` tied low.
- While a load is in progress the loader drives the memory write port and holds the core.
- Sits between the host byte link and the instruction memory's w/addr/w_v inputs.

Parameters:
- DEPTH, 32, number of instruction words in instruction memory; legal word indices 0..DEPTH-1.
- CNT_W, 6, width of the word counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- byte_valid  input  1  host byte present on byte_data.
- byte_data  input  8  host byte.
- byte_ready  output  1  loader accepts byte this cycle; a transfer happens when byte_valid and byte_ready are both 1.
- mem_w  output  1  write strobe to instruction memory w.
- mem_addr  output  32  word address to instruction memory addr; upper bits are zero.
- mem_wdata  output  32  instruction word to instruction memory w_v.
- cpu_hold  output  1  core must not advance while 1.
- done  output  1  one-cycle pulse when a load ends, whether it succeeded or failed.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset (async assert, synchronous release on clk) puts all outputs at 0 except as noted:
  - state=IDLE.
  - byte_ready=0, mem_w=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0.
  - Word index, byte index and word count are all 0.
- Frame format:
  - Byte 0: word count N, unsigned.
  - Then 4*N data bytes, little-endian per word: first byte goes to [7:0], fourth to [31:24].
  - Words are written to indices 0..N-1 in order.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - start=1 -> COUNT; err cleared to 0; cpu_hold=1 from the next cycle.
  - byte_valid is ignored in IDLE and no byte is consumed.
- COUNT: byte_ready=1. On transfer:
  - N=0 -> DONE; no writes.
  - N>DEPTH -> err=1 -> DONE; no writes.
  - otherwise latch N, word index=0, byte index=0 -> DATA.
- DATA:
  - byte_ready=1. Each transfer shifts the byte into assembly register bits [8*b+7:8*b], where b is the byte index; b then increments.
  - On the transfer with b=3 -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_w=1, mem_addr=word index, mem_wdata=assembled word.
  - Next cycle: mem_w=0, word index+1.
  - If the new index equals N -> DONE (or CHECK when the optional feature is enabled); else -> DATA with b=0.
- DONE (one cycle):
  - done=1, byte_ready=0, cpu_hold still 1.
  - Next cycle -> IDLE, with done=0 and cpu_hold=0.
- Latencies:
  - Memory write occurs on the cycle after the 4th byte of a word transfers.
  - done rises 1 cycle after the final write cycle.
- mem_addr and mem_wdata hold their last values when mem_w=0.
- start outside IDLE is ignored.
- byte_valid gaps (stalls) in COUNT/DATA are allowed indefinitely; state is held.
- Simultaneous start and byte_valid in IDLE: only start takes effect; that byte is not consumed.
- Reset mid-load: immediate return to IDLE with all outputs 0. Words already written remain in memory; no further writes occur.
- Word index never exceeds DEPTH-1 on a write, because N is bounded by DEPTH.

Optional Feature:
- Macro: INSN_LOADER_CHECKSUM_EN.
- Defined:
  - A trailing checksum byte follows the data bytes.
  - After the last WRITE the FSM goes to CHECK (byte_ready=1).
  - On transfer, compare against the XOR of the count byte and all data bytes; mismatch -> err=1.
  - Then DONE. Writes already performed are not undone.
  - For N=0 the checksum byte is still expected, with expected value 0x00.
  - For N>DEPTH no checksum byte is consumed.
- Undefined: no CHECK state and no checksum byte; err is caused only by N>DEPTH.

Test Plan:
- Single word: start, bytes 01,78,56,34,12 -> one mem_w pulse with addr=0, wdata=0x12345678; done 1 cycle later; cpu_hold high from the cycle after start through the done cycle; err=0.
- Full load: N=32, word k = 0xA5000000|k sent with random byte_valid gaps -> 32 writes, addr 0..31 in order, correct data; byte_ready=0 on every write cycle; done pulses once.
- Over-size: N=33 (0x21) -> no mem_w; err=1 and done pulse on the cycle after the count byte; the next start clears err.
- Zero / ignore cases:
  - N=0 -> done with no writes.
  - start pulsed during DATA -> ignored.
  - byte_valid held high in IDLE -> byte_ready stays 0.
- Reset mid-load: assert rst_n=0 after 2 of 3 words are written -> all outputs 0 immediately. A fresh load of N=1 with word 0xDEADBEEF then writes addr 0 correctly.
- INSN_LOADER_CHECKSUM_EN:
  - Frame 01,01,02,03,04 with checksum 0x05 -> err=0.
  - Same frame with checksum 0x06 -> write still occurs and err=1 at done.

Source files
------------

// File: rtl/insn_loader.sv
// insn_loader: packs a host byte stream into 32-bit words and writes them to instruction memory.
// Define INSN_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte per frame.
module insn_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
`ifdef INSN_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE} state_t;
`endif
    state_t state;
    logic [CNT_W-1:0] n, widx;
    logic [1:0] bidx;
    logic [23:0] word_buf;
    logic xfer;
    assign xfer = byte_valid & byte_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            byte_ready <= 1'b0;
            mem_w <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_hold <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            n <= '0;
            widx <= '0;
            bidx <= '0;
            word_buf <= '0;
`ifdef INSN_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            done <= 1'b0;
            mem_w <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= COUNT;
                    err <= 1'b0;
                    cpu_hold <= 1'b1;
                    byte_ready <= 1'b1;
                end
                COUNT: if (xfer) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                    csum <= byte_data;
`endif
                    if (32'(byte_data) > DEPTH) begin
                        err <= 1'b1;
                        byte_ready <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end else if (byte_data == 8'd0) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        byte_ready <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        n <= CNT_W'(byte_data);
                        widx <= '0;
                        bidx <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                    csum <= csum ^ byte_data;
`endif
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        byte_ready <= 1'b0;
                        mem_w <= 1'b1;
                        mem_addr <= 32'(widx);
                        mem_wdata <= {byte_data, word_buf};
                        state <= WRITE;
                    end else begin
                        word_buf[8*bidx +: 8] <= byte_data;
                    end
                end
                WRITE: begin
                    widx <= widx + CNT_W'(1);
                    if (widx + CNT_W'(1) == n) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                        byte_ready <= 1'b1;
                        state <= CHECK;
`else
                        done <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        bidx <= '0;
                        byte_ready <= 1'b1;
                        state <= DATA;
                    end
                end
`ifdef INSN_LOADER_CHECKSUM_EN
                CHECK: if (xfer) begin
                    err <= byte_data != csum;
                    byte_ready <= 1'b0;
                    done <= 1'b1;
                    state <= DONE;
                end
`endif
                DONE: begin
                    cpu_hold <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader: scoreboard bench for insn_loader; expected writes are queued as bytes are driven.
module tb_insn_loader;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic byte_ready, mem_w, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;
    int checks = 0, errors = 0, writes = 0, dones = 0;
    logic [63:0] exp_q[$];
    logic [7:0] xs;

    insn_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] e;
    always @(negedge clk) if (rst_n) begin
        if (done) dones++;
        if (mem_w) begin
            writes++;
            if (exp_q.size() == 0) check("spurious_w", 32'(mem_w), 32'd0);
            else begin
                e = exp_q.pop_front();
                check("addr", mem_addr, e[63:32]);
                check("wdata", mem_wdata, e[31:0]);
                check("br_on_w", 32'(byte_ready), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int to;
        repeat ($urandom_range(gap, 0)) begin @(negedge clk); byte_valid = 1'b0; end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        xs = xs ^ b;
        to = 0;
        while (!byte_ready && to < 50) begin @(negedge clk); to++; end
        if (to >= 50) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] w, input int gap);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b0;
        xs = 8'd0;
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        check("br_count", 32'(byte_ready), 32'd1);
    endtask

    task automatic finish_frame(input bit exp_err, input int lat, input string tag);
        int k;
        @(negedge clk);
        byte_valid = 1'b0;
        k = 1;
        while (!done && k < 50) begin @(negedge clk); k++; end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, k, lat);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_hold_done"}, 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hold_drop"}, 32'(cpu_hold), 32'd0);
        check({tag, "_err_sticky"}, 32'(err), 32'(exp_err));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic close_frame(input int n, input bit bad, input string tag);
        bit ex;
        int lat;
        ex = (n > 32) | bad;
        lat = (n == 0 || n > 32) ? 1 : 2;
`ifdef INSN_LOADER_CHECKSUM_EN
        if (n <= 32) begin
            send_byte(xs ^ (bad ? 8'h03 : 8'h00), 0);
            lat = 1;
        end
`endif
        finish_frame(ex, lat, tag);
    endtask

    task automatic run_frame(input int n, input logic [31:0] base, input int gap, input bit bad, input string tag);
        pulse_start();
        send_byte(8'(n), gap);
        if (n <= 32) for (int k = 0; k < n; k++) send_word(32'(k), base | 32'(k), gap);
        close_frame(n, bad, tag);
    endtask

    initial begin
        int w0, d0, k;
        repeat (2) @(negedge clk);
        check("rst_br", 32'(byte_ready), 32'd0);
        check("rst_w", 32'(mem_w), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(cpu_hold), 32'd0);

        run_frame(1, 32'h12345678, 0, 1'b0, "single");

        w0 = writes;
        d0 = dones;
        run_frame(32, 32'hA5000000, 3, 1'b0, "full");
        @(posedge clk);
        check("full_writes", writes - w0, 32);
        check("full_dones", dones - d0, 1);

        w0 = writes;
        run_frame(33, 32'h0, 0, 1'b0, "over");
        @(posedge clk);
        check("over_writes", writes - w0, 0);
        @(negedge clk);
        check("over_err_idle", 32'(err), 32'd1);

        w0 = writes;
        run_frame(0, 32'h0, 0, 1'b0, "zero");
        @(posedge clk);
        check("zero_writes", writes - w0, 0);

        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_br", 32'(byte_ready), 32'd0);
        end
        run_frame(2, 32'h0BAD0000, 1, 1'b0, "idlevalid");

        w0 = writes;
        pulse_start();
        send_byte(8'd2, 0);
        send_word(32'd0, 32'h11111111, 0);
        exp_q.push_back({32'd1, 32'h22334455});
        send_byte(8'h55, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_data_br", 32'(byte_ready), 32'd1);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 1);
        close_frame(2, 1'b0, "startdata");
        @(posedge clk);
        check("startdata_writes", writes - w0, 2);

        w0 = writes;
        pulse_start();
        send_byte(8'd3, 0);
        send_word(32'd0, 32'hC0DE0000, 0);
        send_word(32'd1, 32'hC0DE0001, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        k = 0;
        while (writes < w0 + 2 && k < 50) begin @(negedge clk); k++; end
        check("rst_mid_writes", writes - w0, 2);
        send_byte(8'h99, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_br", 32'(byte_ready), 32'd0);
        check("mid_w", 32'(mem_w), 32'd0);
        check("mid_addr", mem_addr, 32'd0);
        check("mid_wdata", mem_wdata, 32'd0);
        check("mid_hold", 32'(cpu_hold), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 32'hDEADBEEF, 0, 1'b0, "after_rst");

`ifdef INSN_LOADER_CHECKSUM_EN
        run_frame(1, 32'h04030201, 0, 1'b0, "ck_good");
        w0 = writes;
        run_frame(1, 32'h04030201, 0, 1'b1, "ck_bad");
        @(posedge clk);
        check("ck_bad_writes", writes - w0, 1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
